// File: rtl/mm_seq_ctrl_if.sv
// mm_seq_ctrl_if -- byte stream, operand memory, multiplier and result RAM
// signals of the matrix-multiply sequencer, bundled for port connection.
//   rx_valid/rx_data        : received byte strobe and data
//   tx_valid/tx_data/tx_ready: outgoing byte handshake
//   mem_we/mem_sel/mem_addr/mem_wdata : operand write port (sel 0 = A, 1 = B)
//   mult_start/mult_done    : multiplier start pulse / completion strobe
//   res_addr/res_rdata      : result RAM read port (1-cycle read latency)
// modport master = sequencer side, modport slave = surrounding system.
`timescale 1ns/1ps
interface mm_seq_ctrl_if #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned RES_BYTES = 2
);
    logic                     rx_valid;
    logic [7:0]               rx_data;
    logic                     tx_valid;
    logic [7:0]               tx_data;
    logic                     tx_ready;
    logic                     mem_we;
    logic                     mem_sel;
    logic [ADDR_W-1:0]        mem_addr;
    logic [7:0]               mem_wdata;
    logic                     mult_start;
    logic                     mult_done;
    logic [ADDR_W-1:0]        res_addr;
    logic [8*RES_BYTES-1:0]   res_rdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, mult_done, res_rdata,
        output tx_valid, tx_data, mem_we, mem_sel, mem_addr, mem_wdata,
               mult_start, res_addr
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mult_done, res_rdata,
        input  tx_valid, tx_data, mem_we, mem_sel, mem_addr, mem_wdata,
               mult_start, res_addr
    );
endinterface

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl -- byte-stream sequencer for a matrix multiplier.
// Receives a 3-byte header (M, K, N), streams M*K bytes of A and K*N bytes
// of B into operand memory, starts the multiplier, then reads M*N result
// elements and transmits each as RES_BYTES bytes, MSB first.
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   bus (master)       : rx/tx byte streams, operand memory, multiplier and
//                        result RAM signals (see mm_seq_ctrl_if)
//   m_dim/k_dim/n_dim  : latched matrix dimensions
//   state              : current state encoding
//   err                : sticky error flag, cleared by the next header byte
//   done               : one-cycle pulse after the last result byte is taken
`timescale 1ns/1ps
module mm_seq_ctrl #(
    parameter int unsigned DIM_W     = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned RES_BYTES = 2,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic             clk,
    input  logic             rst,
    mm_seq_ctrl_if.master    bus,
    output logic [DIM_W-1:0] m_dim,
    output logic [DIM_W-1:0] k_dim,
    output logic [DIM_W-1:0] n_dim,
    output logic [2:0]       state,
    output logic             err,
    output logic             done
);
    localparam int unsigned CNT_W     = 2 * DIM_W;
    localparam int unsigned RES_W     = 8 * RES_BYTES;
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);
    localparam logic [7:0]  BYTE_LAST = 8'(RES_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        LOAD_A  = 3'd2,
        LOAD_B  = 3'd3,
        COMPUTE = 3'd4,
        SEND    = 3'd5,
        ERROR   = 3'd6
    } state_t;

    // SEND sub-phases: address presented, read data captured, bytes going out
    typedef enum logic [1:0] {
        PH_ADDR,
        PH_CAP,
        PH_XMIT
    } phase_t;

    state_t              st;
    phase_t              phase;
    logic                hdr_n;      // next header byte is n_dim
    logic [CNT_W-1:0]    cnt;        // element index for loads and send
    logic [31:0]         idle_cnt;
    logic [RES_W-1:0]    shreg;      // remaining bytes of current element
    logic [7:0]          byte_idx;

    logic                tx_valid;
    logic [7:0]          tx_data;
    logic                mem_we;
    logic                mem_sel;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_wdata;
    logic                mult_start;
    logic [ADDR_W-1:0]   res_addr;

    // Element counts at full 2*DIM_W width so MAX_DIM*MAX_DIM never truncates
    logic [CNT_W-1:0] mk_last, kn_last, mn_last;
    assign mk_last = CNT_W'(m_dim) * CNT_W'(k_dim) - CNT_W'(1);
    assign kn_last = CNT_W'(k_dim) * CNT_W'(n_dim) - CNT_W'(1);
    assign mn_last = CNT_W'(m_dim) * CNT_W'(n_dim) - CNT_W'(1);

    assign bus.tx_valid   = tx_valid;
    assign bus.tx_data    = tx_data;
    assign bus.mem_we     = mem_we;
    assign bus.mem_sel    = mem_sel;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mult_start = mult_start;
    assign bus.res_addr   = res_addr;
    assign state          = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            phase      <= PH_ADDR;
            hdr_n      <= 1'b0;
            cnt        <= '0;
            idle_cnt   <= '0;
            shreg      <= '0;
            byte_idx   <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            mem_we     <= 1'b0;
            mem_sel    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mult_start <= 1'b0;
            res_addr   <= '0;
            m_dim      <= '0;
            k_dim      <= '0;
            n_dim      <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            mult_start <= 1'b0;
            done       <= 1'b0;

            case (st)
                IDLE: begin
                    if (bus.rx_valid) begin
                        m_dim    <= bus.rx_data[DIM_W-1:0];
                        err      <= 1'b0;
                        hdr_n    <= 1'b0;
                        idle_cnt <= '0;
                        st       <= HDR;
                    end
                end

                HDR, LOAD_A, LOAD_B: begin
                    if (!bus.rx_valid) begin
                        // rx_valid on the expiring cycle takes the other branch
                        if (idle_cnt == TO_LAST) begin
                            idle_cnt <= '0;
                            err      <= 1'b1;
                            tx_valid <= 1'b1;
                            tx_data  <= 8'hEE;
                            st       <= ERROR;
                        end else begin
                            idle_cnt <= idle_cnt + 32'd1;
                        end
                    end else begin
                        idle_cnt <= '0;
                        case (st)
                            HDR: begin
                                if (!hdr_n) begin
                                    k_dim <= bus.rx_data[DIM_W-1:0];
                                    hdr_n <= 1'b1;
                                end else begin
                                    n_dim <= bus.rx_data[DIM_W-1:0];
                                    cnt   <= '0;
                                    if (m_dim == '0 || k_dim == '0 ||
                                        bus.rx_data[DIM_W-1:0] == '0) begin
                                        err      <= 1'b1;
                                        tx_valid <= 1'b1;
                                        tx_data  <= 8'hEE;
                                        st       <= ERROR;
                                    end else begin
                                        st <= LOAD_A;
                                    end
                                end
                            end
                            LOAD_A: begin
                                mem_we    <= 1'b1;
                                mem_sel   <= 1'b0;
                                mem_addr  <= ADDR_W'(cnt);
                                mem_wdata <= bus.rx_data;
                                if (cnt == mk_last) begin
                                    cnt <= '0;
                                    st  <= LOAD_B;
                                end else begin
                                    cnt <= cnt + CNT_W'(1);
                                end
                            end
                            LOAD_B: begin
                                mem_we    <= 1'b1;
                                mem_sel   <= 1'b1;
                                mem_addr  <= ADDR_W'(cnt);
                                mem_wdata <= bus.rx_data;
                                if (cnt == kn_last) begin
                                    cnt        <= '0;
                                    mult_start <= 1'b1;
                                    st         <= COMPUTE;
                                end else begin
                                    cnt <= cnt + CNT_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                COMPUTE: begin
                    if (bus.mult_done) begin
                        cnt      <= '0;
                        res_addr <= '0;
                        phase    <= PH_ADDR;
                        st       <= SEND;
                    end
                end

                SEND: begin
                    case (phase)
                        PH_ADDR: phase <= PH_CAP;
                        PH_CAP: begin
                            tx_data  <= bus.res_rdata[RES_W-1 -: 8];
                            shreg    <= bus.res_rdata << 8;
                            byte_idx <= '0;
                            tx_valid <= 1'b1;
                            phase    <= PH_XMIT;
                        end
                        default: begin
                            if (tx_valid && bus.tx_ready) begin
                                if (byte_idx == BYTE_LAST) begin
                                    tx_valid <= 1'b0;
                                    if (cnt == mn_last) begin
                                        done <= 1'b1;
                                        st   <= IDLE;
                                    end else begin
                                        cnt      <= cnt + CNT_W'(1);
                                        res_addr <= ADDR_W'(cnt + CNT_W'(1));
                                        phase    <= PH_ADDR;
                                    end
                                end else begin
                                    byte_idx <= byte_idx + 8'd1;
                                    tx_data  <= shreg[RES_W-1 -: 8];
                                    shreg    <= shreg << 8;
                                end
                            end
                        end
                    endcase
                end

                ERROR: begin
                    if (tx_valid && bus.tx_ready) begin
                        tx_valid <= 1'b0;
                        st       <= IDLE;
                    end
                end

                default: st <= IDLE;
            endcase
        end
    end
endmodule
